dmem_lsu: RTL and testbench

//  Data-memory initiator: converts pipeline load/store requests into byte-enabled DMEM strobes.
//  - Memory side: the SoC's synchronous single-port DMEM (read data valid 1 cycle after strobe).
//  - Handles byte-lane alignment, load sign/zero extension and misaligned accesses.
//  - Misaligned accesses are split into two aligned beats or flagged as errors.
//  - Sits between the pipeline MEM stage and the DMEM_* port of top_riscV.

---
 rtl/dmem_lsu_pkg.sv | 12 +
 rtl/dmem_lsu_align.sv | 33 +++
 rtl/dmem_lsu.sv | 107 ++++++++++
 tb/tb_dmem_lsu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared funct3 codes, LSU state encoding and size-mask helper.
package dmem_lsu_pkg;
   typedef enum logic [2:0] {IDLE, LD1, LD2, ST2, RESP} lsu_state_t;
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      return sz == 2'd0 ? 4'b0001 : sz == 2'd1 ? 4'b0011 : sz == 2'd2 ? 4'b1111 : 4'b0000;
   endfunction
endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: byte-lane mask, store-data rotation and load extraction for both beats.
module dmem_lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rd_lo,
   input  logic [31:0] rd_hi,
   output logic [7:0]  mask,
   output logic [31:0] wd_lo,
   output logic [31:0] wd_hi,
   output logic [31:0] rdata,
   output logic        split,
   output logic        illegal
);
   logic [63:0] wsh;
   logic [31:0] rsh;
   // loads allow B/H/W/BU/HU, stores only B/H/W
   assign illegal = funct3[1:0] == 2'd3 || (funct3[2] && (we || funct3[1]));
   assign mask    = {4'b0000, size_mask(funct3[1:0])} << off;
   assign split   = |mask[7:4];
   assign wsh     = {32'h0, wdata} << {off, 3'b000};
   assign wd_lo   = wsh[31:0];
   assign wd_hi   = wsh[63:32];
   assign rsh     = 32'({rd_hi, rd_lo} >> {off, 3'b000});
   always_comb
      rdata = funct3 == F3_B  ? {{24{rsh[7]}}, rsh[7:0]} :
              funct3 == F3_H  ? {{16{rsh[15]}}, rsh[15:0]} :
              funct3 == F3_BU ? {24'h0, rsh[7:0]} :
              funct3 == F3_HU ? {16'h0, rsh[15:0]} : rsh;
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: turns pipeline load/store requests into byte-enabled DMEM strobes,
// splitting misaligned accesses into two word beats or rejecting them.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] DMEM_addr_o,
   output logic [31:0] DMEM_data_o,
   output logic [3:0]  DMEM_write_byte_o,
   output logic        DMEM_read_o,
   input  logic [31:0] DMEM_data_i
);
   lsu_state_t  state, state_nx;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [29:0] word_q;
   logic [31:0] wdata_q, lo_q, rdata_q;
   logic        err_q;
   logic        idle, accept, err;
   logic [7:0]  mask;
   logic [31:0] wd_lo, wd_hi, ext;
   logic        split, illegal;
   assign idle        = state == IDLE;
   assign req_ready_o = reset_n && idle;
   assign accept      = req_valid_i && req_ready_o;
   assign err         = illegal || (split && !SPLIT_MISALIGNED);
   // in IDLE the aligner sees the live request, afterwards the captured one
   dmem_lsu_align u_align (
      .we      (req_we_i),
      .funct3  (idle ? req_funct3_i : f3_q),
      .off     (idle ? req_addr_i[1:0] : off_q),
      .wdata   (idle ? req_wdata_i : wdata_q),
      .rd_lo   (state == LD1 ? DMEM_data_i : lo_q),
      .rd_hi   (state == LD2 ? DMEM_data_i : 32'h0),
      .mask    (mask),
      .wd_lo   (wd_lo),
      .wd_hi   (wd_hi),
      .rdata   (ext),
      .split   (split),
      .illegal (illegal)
   );
   always_comb begin
      state_nx          = state;
      DMEM_addr_o       = {idle ? req_addr_i[31:2] : word_q, 2'b00};
      DMEM_data_o       = wd_lo;
      DMEM_write_byte_o = 4'b0000;
      DMEM_read_o       = 1'b0;
      case (state)
         IDLE: if (accept) begin
            state_nx          = err ? RESP : !req_we_i ? LD1 : split ? ST2 : RESP;
            DMEM_write_byte_o = (!err && req_we_i) ? mask[3:0] : 4'b0000;
            DMEM_read_o       = !err && !req_we_i;
         end
         LD1: begin
            state_nx    = split ? LD2 : RESP;
            DMEM_addr_o = {word_q + 30'd1, 2'b00};
            DMEM_read_o = split;
         end
         LD2: state_nx = RESP;
         ST2: begin
            state_nx          = RESP;
            DMEM_addr_o       = {word_q + 30'd1, 2'b00};
            DMEM_data_o       = wd_hi;
            DMEM_write_byte_o = mask[7:4];
         end
         default: state_nx = IDLE;
      endcase
      if (!reset_n) begin
         DMEM_write_byte_o = 4'b0000;
         DMEM_read_o       = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state <= state_nx;
         if (accept) begin
            f3_q    <= req_funct3_i;
            off_q   <= req_addr_i[1:0];
            word_q  <= req_addr_i[31:2];
            wdata_q <= req_wdata_i;
            err_q   <= err;
            rdata_q <= 32'h0;
         end
         if (state == LD1) lo_q <= DMEM_data_i;
         if ((state == LD1 && !split) || state == LD2) rdata_q <= ext;
      end
   end
   assign resp_valid_o = state == RESP;
   assign resp_err_o   = resp_valid_o && err_q;
   assign resp_rdata_o = resp_valid_o ? rdata_q : 32'h0;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed checks of dmem_lsu (split and reject variants) against a word memory model.
module tb_dmem_lsu;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        ready1, resp_valid1, err1, rd1, ready0, resp_valid0, err0, rd0;
   logic [31:0] rdata1, addr1, data1, rdata0, addr0, data0;
   logic [3:0]  wb1, wb0;
   logic [31:0] mrd = 32'h0;
   bit   [31:0] mem [256];
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.SPLIT_MISALIGNED(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_ready_o(ready1),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid1), .resp_rdata_o(rdata1), .resp_err_o(err1),
      .DMEM_addr_o(addr1), .DMEM_data_o(data1), .DMEM_write_byte_o(wb1), .DMEM_read_o(rd1),
      .DMEM_data_i(mrd));

   dmem_lsu #(.SPLIT_MISALIGNED(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_ready_o(ready0),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid0), .resp_rdata_o(rdata0), .resp_err_o(err0),
      .DMEM_addr_o(addr0), .DMEM_data_o(data0), .DMEM_write_byte_o(wb0), .DMEM_read_o(rd0),
      .DMEM_data_i(32'h0));

   function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d, input logic [3:0] we);
      bit [31:0] r = old;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (rd1) mrd <= mem[addr1[9:2]];
      if (|wb1) mem[addr1[9:2]] <= merge(mem[addr1[9:2]], data1, wb1);
   end

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
      req_valid = v; req_we = we; req_funct3 = f; req_addr = a; req_wdata = d;
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      drive(1, 1, 3'd2, 32'h100, 32'h1);
      step;
      tests++; if (ready1 !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", ready1); end
      tests++; if ({wb1, rd1, resp_valid1, err1} !== 7'b0) begin fails++; $display("FAIL rst_strobes got %b want 0", {wb1, rd1, resp_valid1, err1}); end
      tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", rdata1); end
      drive(0, 0, 3'd0, 32'h0, 32'h0);
      step;
      reset_n = 1'b1;
      #1;
      tests++; if (ready1 !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b want 1", ready1); end
   endtask

   task automatic test_sw_aligned;
      drive(1, 1, 3'd2, 32'h100, 32'hDEADBEEF);
      tests++; if (wb1 !== 4'hF || addr1 !== 32'h100 || data1 !== 32'hDEADBEEF || rd1 !== 1'b0)
         begin fails++; $display("FAIL sw_beat got we=%h addr=%h data=%h rd=%b want we=f addr=100 data=deadbeef rd=0", wb1, addr1, data1, rd1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (resp_valid1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'h0 || ready1 !== 1'b0 || wb1 !== 4'h0)
         begin fails++; $display("FAIL sw_ack got v=%b e=%b d=%h rdy=%b we=%h want v=1 e=0 d=0 rdy=0 we=0", resp_valid1, err1, rdata1, ready1, wb1); end
      step;
      tests++; if (resp_valid1 !== 1'b0 || ready1 !== 1'b1) begin fails++; $display("FAIL sw_idle got v=%b rdy=%b want 0 1", resp_valid1, ready1); end
   endtask

   task automatic test_byte;
      drive(1, 1, 3'd0, 32'h103, 32'h000000A5);
      tests++; if (wb1 !== 4'b1000 || data1[31:24] !== 8'hA5 || addr1 !== 32'h100)
         begin fails++; $display("FAIL sb_beat got we=%h data=%h addr=%h want we=8 data[31:24]=a5 addr=100", wb1, data1, addr1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      step;
      drive(1, 0, 3'd0, 32'h103, 32'h0);
      tests++; if (rd1 !== 1'b1 || wb1 !== 4'h0 || addr1 !== 32'h100) begin fails++; $display("FAIL lb_read got rd=%b we=%h addr=%h want 1 0 100", rd1, wb1, addr1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (resp_valid1 !== 1'b0 || rd1 !== 1'b0) begin fails++; $display("FAIL lb_c1 got v=%b rd=%b want 0 0", resp_valid1, rd1); end
      step;
      tests++; if (resp_valid1 !== 1'b1 || rdata1 !== 32'hFFFFFFA5) begin fails++; $display("FAIL lb_data got v=%b d=%h want 1 ffffffa5", resp_valid1, rdata1); end
      step;
      drive(1, 0, 3'd4, 32'h103, 32'h0);
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      step;
      tests++; if (resp_valid1 !== 1'b1 || rdata1 !== 32'h000000A5) begin fails++; $display("FAIL lbu_data got v=%b d=%h want 1 000000a5", resp_valid1, rdata1); end
      step;
   endtask

   task automatic test_split;
      drive(1, 1, 3'd2, 32'h102, 32'h11223344);
      tests++; if (wb1 !== 4'b1100 || addr1 !== 32'h100 || data1[31:16] !== 16'h3344)
         begin fails++; $display("FAIL ssw_b0 got we=%h addr=%h data=%h want we=c addr=100 data[31:16]=3344", wb1, addr1, data1); end
      step; drive(1, 1, 3'd0, 32'h200, 32'hFFFFFFFF);
      tests++; if (wb1 !== 4'b0011 || addr1 !== 32'h104 || data1[15:0] !== 16'h1122 || resp_valid1 !== 1'b0)
         begin fails++; $display("FAIL ssw_b1 got we=%h addr=%h data=%h v=%b want we=3 addr=104 data[15:0]=1122 v=0", wb1, addr1, data1, resp_valid1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (resp_valid1 !== 1'b1 || wb1 !== 4'h0) begin fails++; $display("FAIL ssw_ack got v=%b we=%h want 1 0", resp_valid1, wb1); end
      step;
      drive(1, 0, 3'd2, 32'h102, 32'h0);
      tests++; if (rd1 !== 1'b1 || addr1 !== 32'h100) begin fails++; $display("FAIL slw_r0 got rd=%b addr=%h want 1 100", rd1, addr1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (rd1 !== 1'b1 || addr1 !== 32'h104) begin fails++; $display("FAIL slw_r1 got rd=%b addr=%h want 1 104", rd1, addr1); end
      step;
      tests++; if (resp_valid1 !== 1'b0 || rd1 !== 1'b0) begin fails++; $display("FAIL slw_c2 got v=%b rd=%b want 0 0", resp_valid1, rd1); end
      step;
      tests++; if (resp_valid1 !== 1'b1 || rdata1 !== 32'h11223344) begin fails++; $display("FAIL slw_data got v=%b d=%h want 1 11223344", resp_valid1, rdata1); end
      step;
   endtask

   task automatic test_errors;
      drive(1, 0, 3'd1, 32'h0FF, 32'h0);
      tests++; if (rd0 !== 1'b0 || wb0 !== 4'h0) begin fails++; $display("FAIL rej_strobe got rd=%b we=%h want 0 0", rd0, wb0); end
      tests++; if (rd1 !== 1'b1 || addr1 !== 32'h0FC) begin fails++; $display("FAIL slh_r0 got rd=%b addr=%h want 1 0fc", rd1, addr1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (resp_valid0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 32'h0)
         begin fails++; $display("FAIL rej_resp got v=%b e=%b d=%h want 1 1 0", resp_valid0, err0, rdata0); end
      step; step;
      tests++; if (resp_valid1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'hFFFFEF00)
         begin fails++; $display("FAIL slh_data got v=%b e=%b d=%h want 1 0 ffffef00", resp_valid1, err1, rdata1); end
      step;
      drive(1, 0, 3'd3, 32'h100, 32'h0);
      tests++; if (rd1 !== 1'b0 || rd0 !== 1'b0) begin fails++; $display("FAIL f3_strobe got rd1=%b rd0=%b want 0 0", rd1, rd0); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (resp_valid1 !== 1'b1 || err1 !== 1'b1 || err0 !== 1'b1 || rdata1 !== 32'h0)
         begin fails++; $display("FAIL f3_err got v=%b e1=%b e0=%b d=%h want 1 1 1 0", resp_valid1, err1, err0, rdata1); end
      step;
      drive(1, 1, 3'd4, 32'h100, 32'h0);
      tests++; if (wb1 !== 4'h0) begin fails++; $display("FAIL st_f3_strobe got we=%h want 0", wb1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (err1 !== 1'b1) begin fails++; $display("FAIL st_f3_err got %b want 1", err1); end
      step;
   endtask

   task automatic test_wrap;
      drive(1, 1, 3'd2, 32'hFFFFFFFE, 32'hCAFEF00D);
      tests++; if (wb1 !== 4'b1100 || addr1 !== 32'hFFFFFFFC) begin fails++; $display("FAIL wsw_b0 got we=%h addr=%h want c fffffffc", wb1, addr1); end
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (wb1 !== 4'b0011 || addr1 !== 32'h0) begin fails++; $display("FAIL wsw_b1 got we=%h addr=%h want 3 0", wb1, addr1); end
      step; step;
      drive(1, 0, 3'd2, 32'hFFFFFFFE, 32'h0);
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (rd1 !== 1'b1 || addr1 !== 32'h0) begin fails++; $display("FAIL wlw_r1 got rd=%b addr=%h want 1 0", rd1, addr1); end
      step; step;
      tests++; if (resp_valid1 !== 1'b1 || rdata1 !== 32'hCAFEF00D) begin fails++; $display("FAIL wlw_data got v=%b d=%h want 1 cafef00d", resp_valid1, rdata1); end
      step;
   endtask

   task automatic test_reset_mid;
      drive(1, 1, 3'd2, 32'h102, 32'hAABBCCDD);
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      reset_n = 1'b0;
      #1;
      tests++; if (wb1 !== 4'h0 || rd1 !== 1'b0) begin fails++; $display("FAIL rmid_strobe got we=%h rd=%b want 0 0", wb1, rd1); end
      step;
      tests++; if (resp_valid1 !== 1'b0 || ready1 !== 1'b0) begin fails++; $display("FAIL rmid_resp got v=%b rdy=%b want 0 0", resp_valid1, ready1); end
      reset_n = 1'b1;
      #1;
      tests++; if (ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin fails++; $display("FAIL rmid_idle got rdy=%b v=%b want 1 0", ready1, resp_valid1); end
      drive(1, 0, 3'd2, 32'h104, 32'h0);
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      step;
      tests++; if (resp_valid1 !== 1'b1 || rdata1 !== 32'h00001122) begin fails++; $display("FAIL rmid_mem got v=%b d=%h want 1 00001122", resp_valid1, rdata1); end
      step;
   endtask

   task automatic test_back_to_back;
      drive(1, 1, 3'd2, 32'h108, 32'h00000001);
      step; drive(1, 1, 3'd2, 32'h10C, 32'h00000002);
      tests++; if (ready1 !== 1'b0 || wb1 !== 4'h0 || resp_valid1 !== 1'b1)
         begin fails++; $display("FAIL b2b_resp got rdy=%b we=%h v=%b want 0 0 1", ready1, wb1, resp_valid1); end
      step;
      tests++; if (ready1 !== 1'b1 || wb1 !== 4'hF || addr1 !== 32'h10C || data1 !== 32'h2)
         begin fails++; $display("FAIL b2b_accept got rdy=%b we=%h addr=%h data=%h want 1 f 10c 2", ready1, wb1, addr1, data1); end
      drive(0, 0, 3'd0, 32'h0, 32'h0);
      step; step;
      drive(1, 0, 3'd2, 32'h108, 32'h0);
      step; drive(1, 1, 3'd0, 32'h10C, 32'hFFFFFFFF);
      step; drive(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (resp_valid1 !== 1'b1 || rdata1 !== 32'h00000001) begin fails++; $display("FAIL b2b_sampled got v=%b d=%h want 1 00000001", resp_valid1, rdata1); end
      step;
   endtask

   initial begin
      test_reset;
      test_sw_aligned;
      test_byte;
      test_split;
      test_errors;
      test_wrap;
      test_reset_mid;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
